// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer and its helpers.
package pipeline_ctrl_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } ctrl_state_e;

   localparam int FLUSH_CYCLES_DEF = 2;

   localparam logic [4:0] X0 = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use compare between the IF/ID consumer and the EX producer.
// Register x0 is never a real dependency because writes to it are discarded.
module hazard_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic [4:0] ex_rd,
   input  logic       ex_rf_wb_en,
   input  logic       ex_load_en,
   input  logic       ex_valid,
   output logic       lu
);

   logic producer_is_load;
   logic rs1_match;
   logic rs2_match;

   // A live load writing a non-zero register hazards any decoded reader of that register.
   always_comb begin
      producer_is_load = ex_valid & ex_load_en & ex_rf_wb_en & (ex_rd != X0);
      rs1_match        = id_uses_rs1 & (id_rs1 == ex_rd);
      rs2_match        = id_uses_rs2 & (id_rs2 == ex_rd);
      lu               = producer_is_load & (rs1_match | rs2_match);
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 3-stage core: load-use bubbles, post-redirect
// squash of wrong-path fetches, whole-pipe freeze on memory busy, and the
// stall/flush performance counters.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
   parameter int CNT_W        = 32
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_rf_wb_en,
   input  logic             ex_load_en,
   input  logic             ex_valid,
   input  logic             ex_redirect,
   input  logic             mem_busy,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_kill,
   output logic             ex_bubble,
   output logic             exma_en,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // Squash cycles still owed after the redirect cycle itself.
   localparam logic [2:0]       FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   ctrl_state_e      state_q, state_d;
   logic [2:0]       remaining_q, remaining_d;
   logic             kill_q, kill_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             lu;

   hazard_detect u_hazard_detect (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .ex_rd       (ex_rd),
      .ex_rf_wb_en (ex_rf_wb_en),
      .ex_load_en  (ex_load_en),
      .ex_valid    (ex_valid),
      .lu          (lu)
   );

   // Prioritised next-state and output selection: reset, freeze, redirect, flush, load-use, normal.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      kill_d      = kill_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_kill   = 1'b0;
      ex_bubble   = 1'b0;
      exma_en     = 1'b1;

      if (rst) begin
         ifid_kill = 1'b1;
         ex_bubble = 1'b1;
      end else if (mem_busy) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         exma_en     = 1'b0;
         ifid_kill   = kill_q;
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else if (ex_redirect) begin
         ifid_kill   = 1'b1;
         ex_bubble   = 1'b1;
         kill_d      = 1'b1;
         flush_cnt_d = flush_cnt_q + CNT_ONE;
         if (FLUSH_RELOAD != 3'd0) begin
            state_d     = FLUSH;
            remaining_d = FLUSH_RELOAD;
         end else begin
            state_d     = RUN;
            remaining_d = 3'd0;
         end
      end else if (state_q == FLUSH) begin
         ifid_kill   = 1'b1;
         ex_bubble   = 1'b1;
         kill_d      = 1'b1;
         flush_cnt_d = flush_cnt_q + CNT_ONE;
         if (remaining_q <= 3'd1) begin
            state_d     = RUN;
            remaining_d = 3'd0;
         end else begin
            remaining_d = remaining_q - 3'd1;
         end
      end else if (lu) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         ex_bubble   = 1'b1;
         kill_d      = 1'b0;
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
         kill_d = 1'b0;
      end
   end

   // State, squash countdown, held kill flag and counters, cleared synchronously.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         remaining_q <= 3'd0;
         kill_q      <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         kill_q      <= kill_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; a second instance covers the single-cycle squash variant.
module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_uses_rs1, id_uses_rs2;
   logic        ex_rf_wb_en, ex_load_en, ex_valid, ex_redirect, mem_busy;

   logic        pc_en, ifid_en, ifid_kill, ex_bubble, exma_en;
   logic [31:0] stall_cnt, flush_cnt;
   logic        pc_en1, ifid_en1, ifid_kill1, ex_bubble1, exma_en1;
   logic [31:0] stall_cnt1, flush_cnt1;

   logic [4:0]  outs, outs1;
   int          errors = 0;
   int          checks = 0;

   // Output vectors are {pc_en, ifid_en, ifid_kill, ex_bubble, exma_en}.
   localparam logic [4:0] O_NORM = 5'b11001;
   localparam logic [4:0] O_LU   = 5'b00011;
   localparam logic [4:0] O_KILL = 5'b11111;
   localparam logic [4:0] O_FRZ0 = 5'b00000;
   localparam logic [4:0] O_FRZ1 = 5'b00100;

   always #5 clk = ~clk;

   assign outs  = {pc_en, ifid_en, ifid_kill, ex_bubble, exma_en};
   assign outs1 = {pc_en1, ifid_en1, ifid_kill1, ex_bubble1, exma_en1};

   pipeline_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd(ex_rd), .ex_rf_wb_en(ex_rf_wb_en), .ex_load_en(ex_load_en),
      .ex_valid(ex_valid), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_kill(ifid_kill),
      .ex_bubble(ex_bubble), .exma_en(exma_en),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipeline_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) dut1 (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd(ex_rd), .ex_rf_wb_en(ex_rf_wb_en), .ex_load_en(ex_load_en),
      .ex_valid(ex_valid), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
      .pc_en(pc_en1), .ifid_en(ifid_en1), .ifid_kill(ifid_kill1),
      .ex_bubble(ex_bubble1), .exma_en(exma_en1),
      .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic redir, input logic busy,
                                input logic vld, input logic ld, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2);
      rst         = r;
      ex_redirect = redir;
      mem_busy    = busy;
      ex_valid    = vld;
      ex_load_en  = ld;
      ex_rf_wb_en = 1'b1;
      ex_rd       = rd;
      id_rs1      = rs1;
      id_uses_rs1 = u1;
      id_rs2      = rs2;
      id_uses_rs2 = u2;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic r, input logic redir, input logic busy);
      applyStimulus(r, redir, busy, 1'b1, 1'b0, 5'd3, 5'd4, 1'b1, 5'd6, 1'b1);
   endtask

   // lw x5 in EX, add x6,x5,x1 in ID
   task automatic loadUse(input logic redir, input logic busy);
      applyStimulus(1'b0, redir, busy, 1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd1, 1'b1);
   endtask

   initial begin
      idle(1'b1, 1'b0, 1'b0);
      checkOutput("rst_outs_a", 32'(outs), 32'(O_KILL));
      checkOutput("rst_outs1_a", 32'(outs1), 32'(O_KILL));
      tick();
      idle(1'b1, 1'b0, 1'b0);
      checkOutput("rst_outs_b", 32'(outs), 32'(O_KILL));
      tick();
      checkOutput("rst_stall", stall_cnt, 32'd0);
      checkOutput("rst_flush", flush_cnt, 32'd0);

      idle(1'b0, 1'b0, 1'b0);
      checkOutput("post_rst_norm", 32'(outs), 32'(O_NORM));
      tick();

      // No false hazards
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
      checkOutput("nohaz_x0", 32'(outs), 32'(O_NORM));
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0);
      checkOutput("nohaz_rs2_unused", 32'(outs), 32'(O_NORM));
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1);
      checkOutput("nohaz_nonload", 32'(outs), 32'(O_NORM));
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1);
      checkOutput("nohaz_invalid", 32'(outs), 32'(O_NORM));
      tick();
      checkOutput("nohaz_stall", stall_cnt, 32'd0);
      checkOutput("nohaz_flush", flush_cnt, 32'd0);

      // Load-use via rs1, then the load leaves EX
      loadUse(1'b0, 1'b0);
      checkOutput("lu_rs1", 32'(outs), 32'(O_LU));
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 1'b1, 5'd1, 1'b1);
      checkOutput("lu_after", 32'(outs), 32'(O_NORM));
      checkOutput("lu_stall1", stall_cnt, 32'd1);
      tick();

      // Load-use via rs2
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 5'd2, 1'b1, 5'd9, 1'b1);
      checkOutput("lu_rs2", 32'(outs), 32'(O_LU));
      tick();
      idle(1'b0, 1'b0, 1'b0);
      checkOutput("lu_rs2_after", 32'(outs), 32'(O_NORM));
      checkOutput("lu_stall2", stall_cnt, 32'd2);
      tick();

      // Redirect pulse: two kill cycles at FLUSH_CYCLES=2, one at FLUSH_CYCLES=1
      idle(1'b0, 1'b1, 1'b0);
      checkOutput("redir_c0", 32'(outs), 32'(O_KILL));
      checkOutput("redir1_c0", 32'(outs1), 32'(O_KILL));
      tick();
      idle(1'b0, 1'b0, 1'b0);
      checkOutput("redir_c1", 32'(outs), 32'(O_KILL));
      checkOutput("redir1_c1", 32'(outs1), 32'(O_NORM));
      tick();
      idle(1'b0, 1'b0, 1'b0);
      checkOutput("redir_c2", 32'(outs), 32'(O_NORM));
      checkOutput("redir_flush", flush_cnt, 32'd2);
      checkOutput("redir1_flush", flush_cnt1, 32'd1);
      tick();

      // Redirect together with a load-use: redirect wins
      loadUse(1'b1, 1'b0);
      checkOutput("redir_lu_c0", 32'(outs), 32'(O_KILL));
      tick();
      idle(1'b0, 1'b0, 1'b0);
      checkOutput("redir_lu_c1", 32'(outs), 32'(O_KILL));
      tick();
      idle(1'b0, 1'b0, 1'b0);
      checkOutput("redir_lu_c2", 32'(outs), 32'(O_NORM));
      checkOutput("redir_lu_stall", stall_cnt, 32'd2);
      checkOutput("redir_lu_flush", flush_cnt, 32'd4);
      tick();

      // Redirect again in the last FLUSH cycle: reload gives two more kill cycles
      idle(1'b0, 1'b1, 1'b0);
      checkOutput("rr_c0", 32'(outs), 32'(O_KILL));
      tick();
      idle(1'b0, 1'b1, 1'b0);
      checkOutput("rr_c1", 32'(outs), 32'(O_KILL));
      tick();
      idle(1'b0, 1'b0, 1'b0);
      checkOutput("rr_c2", 32'(outs), 32'(O_KILL));
      tick();
      idle(1'b0, 1'b0, 1'b0);
      checkOutput("rr_c3", 32'(outs), 32'(O_NORM));
      checkOutput("rr_flush", flush_cnt, 32'd7);
      tick();

      // Freeze for 3 cycles on top of a load-use, then one bubble
      for (int i = 0; i < 3; i++) begin
         loadUse(1'b0, 1'b1);
         checkOutput($sformatf("frz_lu_%0d", i), 32'(outs), 32'(O_FRZ0));
         tick();
      end
      loadUse(1'b0, 1'b0);
      checkOutput("frz_lu_bubble", 32'(outs), 32'(O_LU));
      tick();
      idle(1'b0, 1'b0, 1'b0);
      checkOutput("frz_lu_after", 32'(outs), 32'(O_NORM));
      checkOutput("frz_lu_stall", stall_cnt, 32'd6);
      tick();

      // Freeze in FLUSH holds the kill and does not consume squash cycles
      idle(1'b0, 1'b1, 1'b0);
      checkOutput("frzfl_c0", 32'(outs), 32'(O_KILL));
      tick();
      idle(1'b0, 1'b0, 1'b1);
      checkOutput("frzfl_frozen", 32'(outs), 32'(O_FRZ1));
      tick();
      checkOutput("frzfl_flush_hold", flush_cnt, 32'd8);
      checkOutput("frzfl_stall", stall_cnt, 32'd7);
      idle(1'b0, 1'b0, 1'b0);
      checkOutput("frzfl_c1", 32'(outs), 32'(O_KILL));
      tick();
      idle(1'b0, 1'b0, 1'b0);
      checkOutput("frzfl_c2", 32'(outs), 32'(O_NORM));
      checkOutput("frzfl_flush", flush_cnt, 32'd9);
      tick();

      // Redirect pending under a freeze is acted on once memory frees up
      idle(1'b0, 1'b1, 1'b1);
      checkOutput("frzrd_frozen", 32'(outs), 32'(O_FRZ0));
      tick();
      idle(1'b0, 1'b1, 1'b0);
      checkOutput("frzrd_c0", 32'(outs), 32'(O_KILL));
      tick();
      idle(1'b0, 1'b0, 1'b0);
      checkOutput("frzrd_c1", 32'(outs), 32'(O_KILL));
      tick();
      idle(1'b0, 1'b0, 1'b0);
      checkOutput("frzrd_c2", 32'(outs), 32'(O_NORM));
      checkOutput("frzrd_stall", stall_cnt, 32'd8);
      checkOutput("frzrd_flush", flush_cnt, 32'd11);
      tick();

      // Reset during the second squash cycle leaves no residual kill
      idle(1'b0, 1'b1, 1'b0);
      tick();
      idle(1'b1, 1'b0, 1'b0);
      checkOutput("rstfl_outs", 32'(outs), 32'(O_KILL));
      tick();
      idle(1'b0, 1'b0, 1'b0);
      checkOutput("rstfl_after", 32'(outs), 32'(O_NORM));
      checkOutput("rstfl_stall", stall_cnt, 32'd0);
      checkOutput("rstfl_flush", flush_cnt, 32'd0);
      checkOutput("rstfl_flush1", flush_cnt1, 32'd0);
      tick();

      // Freeze right after reset shows the cleared kill flag
      idle(1'b0, 1'b0, 1'b1);
      checkOutput("frz_post_rst", 32'(outs), 32'(O_FRZ0));
      tick();
      checkOutput("frz_post_rst_stall", stall_cnt, 32'd1);

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
